vga_frame_streamer: RTL and testbench
=====================================

Name: vga_frame_streamer

Overview:
- Parametrised next-generation VGA pixel pipeline that merges timing generation and frame-buffer readout into one clocked block on the pixel clock.
- Generates sync, blank and active coordinates for any timing set.
- Places an IMG_W x IMG_H image from external synchronous RAM at offset (X0,Y0), with integer upscaling SCALE, fixed RAM read latency RD_LAT and two pixel formats.
- Sits between the pixel-clock PLL and the DAC pins; the frame-buffer RAM read port is its only memory client.

Parameters:
- HACTIVE, 640, visible pixels per line
- HFP, 16, horizontal front porch (cycles)
- HSYNC, 96, hsync pulse width (cycles)
- HBP, 48, horizontal back porch (cycles)
- VACTIVE, 480, visible lines
- VFP, 10, vertical front porch (lines)
- VSYNC, 2, vsync pulse width (lines)
- VBP, 33, vertical back porch (lines)
- IMG_W, 256, image width in source pixels
- IMG_H, 256, image height in source pixels
- SCALE, 1, integer upscale factor (1..8)
- X0, 192, window left edge (screen pixels)
- Y0, 112, window top edge (screen lines)
- ADDR_W, 18, RAM address width
- RD_LAT, 2, cycles from rdaddress to valid q (1..4)

Ports:
- vgaclk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- mode  in  1  0 = 8-bit grayscale, 1 = RGB332
- border  in  24  {R,G,B} colour for active pixels outside the window
- q  in  8  RAM read data
- rdaddress  out  ADDR_W  RAM read address
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- sync_b  out  1  composite sync, tied 0
- blank_b  out  1  1 = active video
- red  out  8  red channel
- green  out  8  green channel
- blue  out  8  blue channel
- frame_start  out  1  one-cycle pulse with first active pixel of each frame

Behaviour:
- Timing:
  - HTOTAL = HACTIVE+HFP+HSYNC+HBP; VTOTAL likewise.
  - Counters x (0..HTOTAL-1) and y (0..VTOTAL-1); x wraps to 0 and increments y; y wraps to 0 after VTOTAL-1.
- Raw sync/blank:
  - hsync low for x in [HACTIVE+HFP, HACTIVE+HFP+HSYNC).
  - vsync low for y in [VACTIVE+VFP, VACTIVE+VFP+VSYNC).
  - Active when x<HACTIVE and y<VACTIVE.
- Window:
  - Condition X0<=x<X0+IMG_W*SCALE and Y0<=y<Y0+IMG_H*SCALE.
  - Any window part beyond the active area is clipped.
- Address generation (counter-based, no divider):
  - Counters: hsub/vsub (0..SCALE-1), col (0..IMG_W-1), line_base.
  - In window, col advances when hsub==SCALE-1.
  - col and hsub clear at window line start.
  - At the end of each window line, vsub advances; when vsub==SCALE-1, line_base += IMG_W.
  - line_base and vsub clear at x==0,y==0.
- rdaddress:
  - Registered: rdaddress = line_base + col, one cycle after counter state.
  - Holds its last value outside the window.
- Pipeline:
  - q is sampled RD_LAT cycles after rdaddress; colour is registered on the next cycle.
  - Total latency P = RD_LAT+2 cycles.
  - hsync, vsync, blank_b, the window flag and frame_start pass through a P-deep delay line so all outputs align.
- Colour:
  - blank_b=0: RGB = 0.
  - Active and outside the window: border.
  - Window, mode 0: R=G=B=q.
  - Window, mode 1: R={q[7:5],q[7:5],q[7:6]}, G={q[4:2],q[4:2],q[4:3]}, B={q[1:0]} replicated 4x.
- Mode sampling:
  - mode is latched at x==0,y==0; changes mid-frame take effect on the next frame.
  - border is sampled per pixel.
- frame_start:
  - Raw pulse at x==0,y==0, delayed by P.
- Reset (async, any time including mid-line):
  - x=y=0; all sub/col/base counters 0; delay line flushed.
  - Outputs: hsync=1, vsync=1, blank_b=0, RGB=0, rdaddress=0, frame_start=0, sync_b=0.
  - On release, the first rising edge counts x=0,y=0.

Test Plan:
- Timing check:
  - Stimulus: defaults, reset released.
  - Required: hsync low for 96 cycles every 800, first falling edge 660 cycles after release (656+P).
  - Required: vsync low for 1600 cycles starting at line 490.
  - Required: blank_b high 640/800 cycles on lines 0..479 only.
  - Required: frame_start period 420000 cycles.
- Address check:
  - Stimulus: defaults, SCALE=1.
  - Required: rdaddress for pixel (192,112)=0, (447,112)=255, (192,113)=256, (447,367)=65535.
  - Required: rdaddress unchanged at (448..639,y) from its last window value.
- Scaling check:
  - Stimulus: SCALE=2, IMG_W=IMG_H=128.
  - Required: each address held 2 cycles; each row repeated on 2 lines; pixel (194,114) -> address 129.
- Latency and format check:
  - Stimulus: RAM model RD_LAT=2 with q=addr[7:0], mode 0.
  - Required: pixel (200,112) outputs R=G=B=0x08 on the same cycle blank_b is high for it.
  - Required: pixel (100,50) outputs border colour 0x123456.
- RGB332 check:
  - Stimulus: q=0xE3, mode=1.
  - Required: R=0xFF, G=0x00, B=0xFF.
  - Required: mode toggled at line 200 changes colours only from the next frame_start.
- Mid-line reset check:
  - Stimulus: reset asserted at x=300,y=150.
  - Required: outputs go to reset values immediately, without waiting for a clock edge.
  - Required: after release, hsync first falls 660 cycles later and rdaddress 0 appears at (192,112).

Source files
------------

// File: rtl/vga_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_streamer
// Brief    : VGA timing generator fused with a scaled frame-buffer readout.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_streamer #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYNC   = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSYNC   = 2,
    parameter int VBP     = 33,
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int SCALE   = 1,
    parameter int X0      = 192,
    parameter int Y0      = 112,
    parameter int ADDR_W  = 18,
    parameter int RD_LAT  = 2
) (
    input  logic              vgaclk,
    input  logic              reset,
    input  logic              mode,
    input  logic [23:0]       border,
    input  logic [7:0]        q,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              hsync,
    output logic              vsync,
    output logic              sync_b,
    output logic              blank_b,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              frame_start
);
    localparam int c_htotal = HACTIVE + HFP + HSYNC + HBP;
    localparam int c_vtotal = VACTIVE + VFP + VSYNC + VBP;
    localparam int c_xw     = $clog2(c_htotal);
    localparam int c_yw     = $clog2(c_vtotal);
    localparam int c_p      = RD_LAT + 2;
    localparam int c_win_w  = IMG_W * SCALE;
    localparam int c_win_h  = IMG_H * SCALE;

    logic [c_xw-1:0]   r_x;
    logic [c_yw-1:0]   r_y;
    logic [31:0]       w_xi;
    logic [31:0]       w_yi;
    logic              w_x_last;
    logic              w_y_last;
    logic              w_hs;
    logic              w_vs;
    logic              w_act;
    logic              w_win_x;
    logic              w_win_y;
    logic              w_win;
    logic              w_fs;
    logic [3:0]        r_hsub;
    logic [3:0]        r_vsub;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_line_base;
    logic [ADDR_W-1:0] r_rdaddress;
    logic              r_mode;
    logic [c_p-1:0]    r_hs_dl;
    logic [c_p-1:0]    r_vs_dl;
    logic [c_p-1:0]    r_act_dl;
    logic [c_p-1:0]    r_win_dl;
    logic [c_p-1:0]    r_fs_dl;
    logic [7:0]        r_red;
    logic [7:0]        r_green;
    logic [7:0]        r_blue;

    assign w_xi     = 32'(r_x);
    assign w_yi     = 32'(r_y);
    assign w_x_last = (w_xi == c_htotal - 1);
    assign w_y_last = (w_yi == c_vtotal - 1);
    assign w_hs     = !((w_xi >= HACTIVE + HFP) && (w_xi < HACTIVE + HFP + HSYNC));
    assign w_vs     = !((w_yi >= VACTIVE + VFP) && (w_yi < VACTIVE + VFP + VSYNC));
    assign w_act    = (w_xi < HACTIVE) && (w_yi < VACTIVE);
    assign w_win_x  = (w_xi >= X0) && (w_xi < X0 + c_win_w);
    assign w_win_y  = (w_yi >= Y0) && (w_yi < Y0 + c_win_h);
    assign w_win    = w_act && w_win_x && w_win_y;
    assign w_fs     = (r_x == '0) && (r_y == '0);

    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_x_last) begin
            r_x <= '0;
            r_y <= w_y_last ? '0 : r_y + c_yw'(1);
        end else begin
            r_x <= r_x + c_xw'(1);
        end
    end

    // Counter state always describes the pixel currently at (r_x, r_y); the
    // frame clear happens on the last pixel so (0,0) already sees zeros.
    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            r_hsub      <= '0;
            r_col       <= '0;
            r_vsub      <= '0;
            r_line_base <= '0;
        end else begin
            if (!w_win_x) begin
                r_hsub <= '0;
                r_col  <= '0;
            end else if (r_hsub == 4'(SCALE - 1)) begin
                r_hsub <= '0;
                r_col  <= r_col + ADDR_W'(1);
            end else begin
                r_hsub <= r_hsub + 4'd1;
            end

            if (w_x_last && w_y_last) begin
                r_vsub      <= '0;
                r_line_base <= '0;
            end else if (w_x_last && w_win_y) begin
                if (r_vsub == 4'(SCALE - 1)) begin
                    r_vsub      <= '0;
                    r_line_base <= r_line_base + ADDR_W'(IMG_W);
                end else begin
                    r_vsub <= r_vsub + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            r_rdaddress <= '0;
            r_mode      <= 1'b0;
            r_hs_dl     <= '1;
            r_vs_dl     <= '1;
            r_act_dl    <= '0;
            r_win_dl    <= '0;
            r_fs_dl     <= '0;
        end else begin
            if (w_win) begin
                r_rdaddress <= r_line_base + r_col;
            end
            if (w_fs) begin
                r_mode <= mode;
            end
            r_hs_dl  <= {r_hs_dl[c_p-2:0], w_hs};
            r_vs_dl  <= {r_vs_dl[c_p-2:0], w_vs};
            r_act_dl <= {r_act_dl[c_p-2:0], w_act};
            r_win_dl <= {r_win_dl[c_p-2:0], w_win};
            r_fs_dl  <= {r_fs_dl[c_p-2:0], w_fs};
        end
    end

    // Stage c_p-2 of the delay line lines up with q for the same pixel.
    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            {r_red, r_green, r_blue} <= '0;
        end else if (!r_act_dl[c_p-2]) begin
            {r_red, r_green, r_blue} <= '0;
        end else if (!r_win_dl[c_p-2]) begin
            {r_red, r_green, r_blue} <= border;
        end else if (!r_mode) begin
            {r_red, r_green, r_blue} <= {q, q, q};
        end else begin
            r_red   <= {q[7:5], q[7:5], q[7:6]};
            r_green <= {q[4:2], q[4:2], q[4:3]};
            r_blue  <= {4{q[1:0]}};
        end
    end

    assign rdaddress   = r_rdaddress;
    assign hsync       = r_hs_dl[c_p-1];
    assign vsync       = r_vs_dl[c_p-1];
    assign blank_b     = r_act_dl[c_p-1];
    assign frame_start = r_fs_dl[c_p-1];
    assign sync_b      = 1'b0;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_streamer
// Brief    : Scoreboard bench driving four streamer configurations in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_streamer;
    localparam int N  = 4;
    localparam int AW = 18;
    localparam int C_HACT [N] = '{64, 64, 64, 640};
    localparam int C_HFP  [N] = '{4, 4, 4, 16};
    localparam int C_HSY  [N] = '{8, 8, 8, 96};
    localparam int C_HBP  [N] = '{4, 4, 4, 48};
    localparam int C_VACT [N] = '{40, 40, 40, 480};
    localparam int C_VFP  [N] = '{2, 2, 2, 10};
    localparam int C_VSY  [N] = '{2, 2, 2, 2};
    localparam int C_VBP  [N] = '{3, 3, 3, 33};
    localparam int C_IW   [N] = '{16, 16, 16, 256};
    localparam int C_IH   [N] = '{12, 12, 8, 256};
    localparam int C_SC   [N] = '{1, 3, 2, 1};
    localparam int C_X0   [N] = '{20, 30, 0, 192};
    localparam int C_Y0   [N] = '{10, 20, 0, 112};
    localparam int C_LAT  [N] = '{2, 4, 1, 2};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        sb;
        logic        bl;
        logic [23:0] rgb;
        logic        fs;
    } out_t;

    logic          vgaclk = 1'b0;
    logic          reset  = 1'b0;
    logic          mode        [N];
    logic [23:0]   border      [N];
    logic [7:0]    q           [N];
    logic [AW-1:0] rdaddress   [N];
    logic          hsync       [N];
    logic          vsync       [N];
    logic          sync_b      [N];
    logic          blank_b     [N];
    logic [7:0]    red         [N];
    logic [7:0]    green       [N];
    logic [7:0]    blue        [N];
    logic          frame_start [N];

    logic [7:0]    mem [1024];
    logic [7:0]    rp  [N][4];

    out_t          exp_out [N][$];
    logic [AW-1:0] exp_rd  [N][$];
    int            pix        [N];
    int            last_addr  [N];
    logic          frame_mode [N];
    logic [23:0]   line_border[N];

    int   total   = 0;
    int   bad     = 0;
    logic running = 1'b0;

    always #5 vgaclk = ~vgaclk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            vga_frame_streamer #(
                .HACTIVE(C_HACT[g]), .HFP(C_HFP[g]), .HSYNC(C_HSY[g]), .HBP(C_HBP[g]),
                .VACTIVE(C_VACT[g]), .VFP(C_VFP[g]), .VSYNC(C_VSY[g]), .VBP(C_VBP[g]),
                .IMG_W(C_IW[g]), .IMG_H(C_IH[g]), .SCALE(C_SC[g]),
                .X0(C_X0[g]), .Y0(C_Y0[g]), .ADDR_W(AW), .RD_LAT(C_LAT[g])
            ) u_dut (
                .vgaclk(vgaclk),
                .reset(reset),
                .mode(mode[g]),
                .border(border[g]),
                .q(q[g]),
                .rdaddress(rdaddress[g]),
                .hsync(hsync[g]),
                .vsync(vsync[g]),
                .sync_b(sync_b[g]),
                .blank_b(blank_b[g]),
                .red(red[g]),
                .green(green[g]),
                .blue(blue[g]),
                .frame_start(frame_start[g])
            );
        end
    endgenerate

    // Synchronous RAM with a per-instance read latency.
    always @(posedge vgaclk) begin
        for (int i = 0; i < N; i++) begin
            rp[i][0] <= mem[rdaddress[i][9:0]];
            for (int k = 1; k < 4; k++) rp[i][k] <= rp[i][k-1];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) q[i] = rp[i][C_LAT[i]-1];
    end

    // 3-bit and 2-bit channel expansion as full-scale rounding.
    function automatic logic [7:0] expand3(input logic [2:0] a);
        return 8'((int'(a) * 510 + 7) / 14);
    endfunction

    function automatic logic [7:0] expand2(input logic [1:0] a);
        return 8'(int'(a) * 85);
    endfunction

    // Predicts pixel pix[i]; also chooses that instance's inputs for it.
    task automatic model_step(input int i);
        int   htot, vtot, x, y, addr;
        logic act, win;
        logic [7:0] d;
        out_t o;
        htot = C_HACT[i] + C_HFP[i] + C_HSY[i] + C_HBP[i];
        vtot = C_VACT[i] + C_VFP[i] + C_VSY[i] + C_VBP[i];
        x = pix[i] % htot;
        y = (pix[i] / htot) % vtot;
        if (x == 0) begin
            border[i] = 24'($urandom);
            line_border[i] = border[i];
            if ($urandom_range(3) == 0) mode[i] = ~mode[i];
            if (y == 0) frame_mode[i] = mode[i];
        end
        act = (x < C_HACT[i]) && (y < C_VACT[i]);
        win = act && (x >= C_X0[i]) && (x < C_X0[i] + C_IW[i] * C_SC[i])
                  && (y >= C_Y0[i]) && (y < C_Y0[i] + C_IH[i] * C_SC[i]);
        addr = ((y - C_Y0[i]) / C_SC[i]) * C_IW[i] + (x - C_X0[i]) / C_SC[i];
        o.hs = !((x >= C_HACT[i] + C_HFP[i]) && (x < C_HACT[i] + C_HFP[i] + C_HSY[i]));
        o.vs = !((y >= C_VACT[i] + C_VFP[i]) && (y < C_VACT[i] + C_VFP[i] + C_VSY[i]));
        o.sb = 1'b0;
        o.bl = act;
        o.fs = (x == 0) && (y == 0);
        if (!act) begin
            o.rgb = 24'h0;
        end else if (!win) begin
            o.rgb = line_border[i];
        end else begin
            d = mem[addr % 1024];
            if (frame_mode[i]) o.rgb = {expand3(d[7:5]), expand3(d[4:2]), expand2(d[1:0])};
            else               o.rgb = {d, d, d};
        end
        exp_out[i].push_back(o);
        if (win) last_addr[i] = addr;
        exp_rd[i].push_back(AW'(last_addr[i]));
        pix[i]++;
    endtask

    // Releases reset; the pipeline is expected flushed for its first P stages.
    task automatic start_run();
        out_t r;
        r = '{hs: 1'b1, vs: 1'b1, sb: 1'b0, bl: 1'b0, rgb: 24'h0, fs: 1'b0};
        for (int i = 0; i < N; i++) begin
            exp_out[i].delete();
            exp_rd[i].delete();
            pix[i] = 0;
            last_addr[i] = 0;
            for (int k = 0; k < C_LAT[i] + 2; k++) exp_out[i].push_back(r);
            exp_rd[i].push_back('0);
        end
        reset = 1'b1;
        for (int i = 0; i < N; i++) model_step(i);
        running = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < N; i++) begin
            total++;
            if (hsync[i] !== 1'b1 || vsync[i] !== 1'b1 || sync_b[i] !== 1'b0 ||
                blank_b[i] !== 1'b0 || {red[i], green[i], blue[i]} !== 24'h0 ||
                frame_start[i] !== 1'b0 || rdaddress[i] !== '0) begin
                bad++;
                $display("FAIL %s dut%0d: got hs=%b vs=%b sb=%b bl=%b rgb=%06h fs=%b rd=%0d, want hs=1 vs=1 sb=0 bl=0 rgb=000000 fs=0 rd=0",
                         tag, i, hsync[i], vsync[i], sync_b[i], blank_b[i],
                         {red[i], green[i], blue[i]}, frame_start[i], rdaddress[i]);
            end
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge vgaclk);
            #1;
            for (int i = 0; i < N; i++) model_step(i);
        end
    endtask

    // Monitor: one expected record per instance per pixel-clock stage.
    initial begin
        out_t e, got;
        logic [AW-1:0] er;
        forever begin
            @(negedge vgaclk);
            if (running) begin
                for (int i = 0; i < N; i++) begin
                    total++;
                    if (exp_out[i].size() == 0 || exp_rd[i].size() == 0) begin
                        bad++;
                        $display("FAIL underflow dut%0d at %0t: got empty queue, want a record", i, $time);
                    end else begin
                        e  = exp_out[i].pop_front();
                        er = exp_rd[i].pop_front();
                        got = {hsync[i], vsync[i], sync_b[i], blank_b[i],
                               red[i], green[i], blue[i], frame_start[i]};
                        if (got !== e) begin
                            bad++;
                            $display("FAIL video dut%0d at %0t: got hs=%b vs=%b sb=%b bl=%b rgb=%06h fs=%b, want hs=%b vs=%b sb=%b bl=%b rgb=%06h fs=%b",
                                     i, $time, got.hs, got.vs, got.sb, got.bl, got.rgb, got.fs,
                                     e.hs, e.vs, e.sb, e.bl, e.rgb, e.fs);
                        end
                        total++;
                        if (rdaddress[i] !== er) begin
                            bad++;
                            $display("FAIL rdaddress dut%0d at %0t: got %0d, want %0d",
                                     i, $time, rdaddress[i], er);
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 8'($urandom);
        for (int i = 0; i < N; i++) begin
            mode[i]   = 1'b0;
            border[i] = 24'h0;
        end
        repeat (3) @(posedge vgaclk);
        #1;
        check_reset("reset_state");
        start_run();
        run_cycles(5000 + $urandom_range(0, 300));

        // Asynchronous reset mid-line, checked before any further clock edge.
        @(posedge vgaclk);
        #3;
        running = 1'b0;
        reset   = 1'b0;
        #1;
        check_reset("async_reset");
        repeat (4) @(posedge vgaclk);
        #1;
        check_reset("held_reset");
        start_run();
        run_cycles(8000);

        @(negedge vgaclk);
        #1;
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
